// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the basic CPU datapath blocks.
//   WORD_W      : datapath word length, default width of the serial transmitter
//   tx_state_t  : transmitter control states (IDLE, SHIFT)
//   cnt_width() : bit-counter width for a given word length (never below 1)
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

  // A 1-bit word still needs a 1-bit counter so the port stays legal.
  function automatic int cnt_width(input int width);
    if (width > 1) begin
      return $clog2(width);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/piso_bitcnt.sv
// -----------------------------------------------------------------------------
// piso_bitcnt
// Bit-position counter for the serial transmitter. Counts 0..WIDTH-1 and
// saturates at WIDTH-1; it never wraps, the owner clears it instead.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset (count -> 0)
//   clr    in   synchronous clear (count -> 0), lower priority than rst
//   en     in   advance by one, ignored once at_max is reached
//   at_max out  count == WIDTH-1 (decoded from the count register)
// -----------------------------------------------------------------------------
module piso_bitcnt
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic at_max
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count_r;

  // Count register: reset, clear, saturating increment, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && (count_r != MAX_CNT)) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Terminal-count decode, purely from the register.
  always_comb begin
    at_max = (count_r == MAX_CNT);
  end

endmodule

// File: rtl/piso16_tx.sv
// -----------------------------------------------------------------------------
// piso16_tx
// Parallel-in / serial-out transmitter with a valid/ready style handshake on
// the serial side. A word is captured when load is seen while idle and is then
// shifted out one bit per edge on which the downstream accepts (sready).
// Parameters:
//   WIDTH      word length (default cpu_pkg::WORD_W)
//   MSB_FIRST  0: bit 0 leaves first, 1: bit WIDTH-1 leaves first
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   load        in   parallel-load strobe, honoured only while ready
//   vecin       in   parallel word, sampled on the load edge
//   ready       out  idle, able to accept load
//   sout        out  current serial bit (0 while idle)
//   sout_valid  out  sout carries a bit of the current word
//   sready      in   downstream takes sout on this edge
//   last        out  the bit on sout is the final bit of the word
// All outputs come from registers; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module piso16_tx
  import cpu_pkg::*;
#(
  parameter int WIDTH     = WORD_W,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] vecin,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sready,
  output logic             last
);

  tx_state_t        state_r;
  logic [WIDTH-1:0] shreg_r;
  logic             ready_r;
  logic             sout_valid_r;
  logic             sout_r;

  logic             load_acc_s;
  logic             xfer_s;
  logic             final_s;
  logic             cnt_clr_s;
  logic             cnt_en_s;
  logic             at_max_s;
  logic [WIDTH-1:0] shifted_s;
  logic             first_bit_s;
  logic             next_bit_s;

  // Handshake decode and next shift-register contents.
  always_comb begin
    load_acc_s  = (state_r == IDLE) && load;
    xfer_s      = (state_r == SHIFT) && sready;
    final_s     = xfer_s && at_max_s;
    // Clearing on the final transfer leaves the counter at 0 while idle.
    cnt_clr_s   = load_acc_s || final_s;
    cnt_en_s    = xfer_s && !at_max_s;
    if (MSB_FIRST) begin
      shifted_s   = shreg_r << 1;
      first_bit_s = vecin[WIDTH-1];
      next_bit_s  = shifted_s[WIDTH-1];
    end else begin
      shifted_s   = shreg_r >> 1;
      first_bit_s = vecin[0];
      next_bit_s  = shifted_s[0];
    end
  end

  piso_bitcnt #(
    .WIDTH (WIDTH)
  ) u_bitcnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr_s),
    .en     (cnt_en_s),
    .at_max (at_max_s)
  );

  // Control FSM with shift register; sout is registered alongside the shift
  // so it always equals the output-end bit of shreg while in SHIFT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      shreg_r      <= '0;
      ready_r      <= 1'b1;
      sout_valid_r <= 1'b0;
      sout_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load) begin
            state_r      <= SHIFT;
            shreg_r      <= vecin;
            ready_r      <= 1'b0;
            sout_valid_r <= 1'b1;
            sout_r       <= first_bit_s;
          end else begin
            state_r      <= IDLE;
            shreg_r      <= shreg_r;
            ready_r      <= 1'b1;
            sout_valid_r <= 1'b0;
            sout_r       <= 1'b0;
          end
        end
        SHIFT: begin
          if (final_s) begin
            state_r      <= IDLE;
            shreg_r      <= '0;
            ready_r      <= 1'b1;
            sout_valid_r <= 1'b0;
            sout_r       <= 1'b0;
          end else if (xfer_s) begin
            state_r      <= SHIFT;
            shreg_r      <= shifted_s;
            ready_r      <= 1'b0;
            sout_valid_r <= 1'b1;
            sout_r       <= next_bit_s;
          end else begin
            // Stall: everything holds, load is ignored.
            state_r      <= SHIFT;
            shreg_r      <= shreg_r;
            ready_r      <= 1'b0;
            sout_valid_r <= 1'b1;
            sout_r       <= sout_r;
          end
        end
        default: begin
          state_r      <= IDLE;
          shreg_r      <= '0;
          ready_r      <= 1'b1;
          sout_valid_r <= 1'b0;
          sout_r       <= 1'b0;
        end
      endcase
    end
  end

  // Output drive; last is qualified by valid so an idle counter never shows.
  always_comb begin
    ready      = ready_r;
    sout_valid = sout_valid_r;
    sout       = sout_r;
    last       = sout_valid_r && at_max_s;
  end

endmodule

// File: tb/tb_piso16_tx.sv
// -----------------------------------------------------------------------------
// tb_piso16_tx
// Drives an LSB-first and an MSB-first instance with identical stimulus and
// compares them every cycle against a word/bit-index model of the transmitter.
// Directed scenarios add literal expectations on reassembled words.
// -----------------------------------------------------------------------------
module tb_piso16_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic        sready;
  logic [15:0] vecin;

  logic ready_l, sout_l, sv_l, last_l;
  logic ready_m, sout_m, sv_m, last_m;

  piso16_tx #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load(load), .vecin(vecin), .ready(ready_l),
    .sout(sout_l), .sout_valid(sv_l), .sready(sready), .last(last_l)
  );

  piso16_tx #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .load(load), .vecin(vecin), .ready(ready_m),
    .sout(sout_m), .sout_valid(sv_m), .sready(sready), .last(last_m)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: busy flag, word being sent, index of the bit currently shown
  bit          m_busy [2];
  int          m_idx  [2];
  logic [15:0] m_word [2];

  // collector of bits actually accepted from each DUT
  logic [15:0] acc    [2];
  int          nb     [2];
  int          nwords [2];
  logic [15:0] lastw  [2];
  logic [15:0] prevw  [2];
  int          vcyc   [2];

  task automatic check(input string name, input int d, input logic [15:0] act,
                       input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
    end
  endtask

  // One clock: compare at negedge, collect, update model at posedge.
  task automatic tick();
    logic [1:0] r, v, s, l;
    logic       eb;
    @(negedge clk);
    r = {ready_m, ready_l};
    v = {sv_m, sv_l};
    s = {sout_m, sout_l};
    l = {last_m, last_l};
    for (int d = 0; d < 2; d++) begin
      eb = m_busy[d] ? m_word[d][(d == 1) ? (15 - m_idx[d]) : m_idx[d]] : 1'b0;
      check("ready", d, 16'(r[d]), 16'(!m_busy[d]));
      check("sout_valid", d, 16'(v[d]), 16'(m_busy[d]));
      check("sout", d, 16'(s[d]), 16'(eb));
      check("last", d, 16'(l[d]), 16'(m_busy[d] && (m_idx[d] == 15)));
      if (rst) begin
        acc[d] = 16'h0000;
        nb[d]  = 0;
      end else begin
        if (v[d] === 1'b1) vcyc[d]++;
        if ((v[d] === 1'b1) && sready) begin
          if (d == 0) acc[d] = {s[d], acc[d][15:1]};
          else        acc[d] = {acc[d][14:0], s[d]};
          nb[d]++;
          if (l[d] === 1'b1) begin
            check("bits_per_word", d, 16'(nb[d]), 16'd16);
            prevw[d] = lastw[d];
            lastw[d] = acc[d];
            nwords[d]++;
            nb[d]    = 0;
          end
        end
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] = 1'b0;
      end else if (!m_busy[d] && load) begin
        m_busy[d] = 1'b1;
        m_word[d] = vecin;
        m_idx[d]  = 0;
      end else if (m_busy[d] && sready) begin
        if (m_idx[d] == 15) m_busy[d] = 1'b0;
        else                m_idx[d]++;
      end
    end
    #1;
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((ready_l !== 1'b1) && (n < budget)) begin
      tick();
      n++;
    end
    check("idle_wait", 0, 16'(ready_l), 16'h0001);
  endtask

  task automatic send(input logic [15:0] w);
    vecin = w;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  int w0, vc0, vc1, idle, n;

  initial begin
    for (int d = 0; d < 2; d++) begin
      acc[d] = 16'h0000; nb[d] = 0; nwords[d] = 0; lastw[d] = 16'h0000;
      prevw[d] = 16'h0000; vcyc[d] = 0; m_idx[d] = 0; m_word[d] = 16'h0000;
    end
    rst = 1'b1; load = 1'b0; sready = 1'b0; vecin = 16'h0000;
    @(posedge clk);
    #1;
    tick();
    tick();
    check("rst_ready", 0, 16'(ready_l), 16'h0001);
    check("rst_valid", 0, 16'(sv_l), 16'h0000);
    check("rst_sout", 1, 16'(sout_m), 16'h0000);
    check("rst_last", 1, 16'(last_m), 16'h0000);
    rst = 1'b0;
    sready = 1'b1;
    tick();

    // 000F, no stalls
    w0 = nwords[0]; vc0 = vcyc[0];
    send(16'h000F);
    run_until_idle(40);
    check("w000f_lsb", 0, lastw[0], 16'h000F);
    check("w000f_msb", 1, lastw[1], 16'h000F);
    check("w000f_count", 0, 16'(nwords[0] - w0), 16'd1);
    check("w000f_vcyc", 0, 16'(vcyc[0] - vc0), 16'd16);
    tick();

    // 8001: first shown bit 1 on both orders, then 0 on MSB-first
    vc1 = vcyc[1];
    send(16'h8001);
    check("w8001_first_m", 1, 16'(sout_m), 16'h0001);
    check("w8001_first_l", 0, 16'(sout_l), 16'h0001);
    tick();
    check("w8001_second_m", 1, 16'(sout_m), 16'h0000);
    run_until_idle(40);
    check("w8001_msb", 1, lastw[1], 16'h8001);
    check("w8001_vcyc", 1, 16'(vcyc[1] - vc1), 16'd16);

    // 00AA with a three-cycle stall while bit 2 is shown
    vc0 = vcyc[0];
    send(16'h00AA);
    tick();
    tick();
    check("stall_bit2", 0, 16'(sout_l), 16'h0000);
    sready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", 0, 16'(sout_l), 16'h0000);
    end
    sready = 1'b1;
    run_until_idle(40);
    check("w00aa_lsb", 0, lastw[0], 16'h00AA);
    check("w00aa_vcyc", 0, 16'(vcyc[0] - vc0), 16'd19);

    // load pulse during bit 5 of FFFF is ignored
    w0 = nwords[0];
    send(16'hFFFF);
    for (int i = 0; i < 5; i++) tick();
    vecin = 16'h0000; load = 1'b1;
    tick();
    load = 1'b0;
    run_until_idle(40);
    for (int i = 0; i < 3; i++) tick();
    check("wffff_lsb", 0, lastw[0], 16'hFFFF);
    check("wffff_msb", 1, lastw[1], 16'hFFFF);
    check("wffff_count", 0, 16'(nwords[0] - w0), 16'd1);
    check("wffff_idle", 0, 16'(sv_l), 16'h0000);

    // reset while bit 7 of 1234 is shown
    w0 = nwords[0];
    send(16'h1234);
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready", 0, 16'(ready_l), 16'h0001);
    check("mid_rst_valid", 1, 16'(sv_m), 16'h0000);
    check("mid_rst_sout", 0, 16'(sout_l), 16'h0000);
    check("mid_rst_last", 0, 16'(last_l), 16'h0000);
    check("mid_rst_nowords", 0, 16'(nwords[0] - w0), 16'd0);
    send(16'h0001);
    run_until_idle(40);
    check("w0001_lsb", 0, lastw[0], 16'h0001);
    check("w0001_msb", 1, lastw[1], 16'h0001);

    // back-to-back with load held high
    w0 = nwords[0]; idle = 0; n = 0;
    vecin = 16'h000F; load = 1'b1;
    tick();
    vecin = 16'hF000;
    while (((nwords[0] - w0) < 2) && (n < 80)) begin
      if (ready_l === 1'b1) idle++;
      tick();
      n++;
    end
    load = 1'b0;
    check("b2b_count", 0, 16'(nwords[0] - w0), 16'd2);
    check("b2b_first", 0, prevw[0], 16'h000F);
    check("b2b_second", 0, lastw[0], 16'hF000);
    check("b2b_second_m", 1, lastw[1], 16'hF000);
    check("b2b_idle_gap", 0, 16'(idle), 16'd1);
    tick();
    tick();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 59) == 0);
      load   = ($urandom_range(0, 2) == 0);
      sready = ($urandom_range(0, 3) != 0);
      vecin  = 16'($urandom);
      tick();
    end
    rst = 1'b0; load = 1'b0; sready = 1'b1;
    run_until_idle(40);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
